// File: rtl/record_assembler_pkg.sv
// Shared types and default sizing for the packed-record assembler.
package record_assembler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } record_assembler_state_e;

    localparam int RA_FIELD_W_DEF    = 10;
    localparam int RA_NUM_FIELDS_DEF = 2;

endpackage

// File: rtl/record_assembler_fifo.sv
// Small circular FIFO with a registered head word; pointers wrap modulo DEPTH.
module record_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] head_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        push_ok   = push && !full;
        pop_ok    = pop && !empty;
        rd_nxt    = pop_ok ? ptr_inc(rd_ptr) : rd_ptr;
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        // The slot being written this cycle becomes head only when nothing older remains.
        head_nxt = (push_ok && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            head_data <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/record_assembler.sv
// Field-serial packed-record builder feeding a valid/ready record FIFO.
// Optional sticky duplicate-write flag: define RECORD_ASSEMBLER_DUP_CHECK_EN.
module record_assembler
    import record_assembler_pkg::*;
#(
    parameter int                  FIELD_W     = RA_FIELD_W_DEF,
    parameter int                  NUM_FIELDS  = RA_NUM_FIELDS_DEF,
    parameter logic [FIELD_W-1:0]  DEFAULT_VAL = '0,
    parameter int                  DEPTH       = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_wr_valid,
    input  logic [$clog2(NUM_FIELDS)-1:0]    i_wr_field,
    input  logic [FIELD_W-1:0]               i_wr_data,
    input  logic                             i_wr_last,
    output logic                             o_wr_ready,
    output logic                             o_rec_valid,
    output logic [NUM_FIELDS*FIELD_W-1:0]    o_rec_data,
    input  logic                             i_rec_ready,
    output logic [NUM_FIELDS-1:0]            o_fill_mask,
    output logic                             o_idx_err
`ifdef RECORD_ASSEMBLER_DUP_CHECK_EN
    ,
    output logic                             o_dup_err
`endif
);
    localparam int               IDX_W = $clog2(NUM_FIELDS);
    localparam int               REC_W = NUM_FIELDS * FIELD_W;
    localparam logic [IDX_W:0]   NF    = (IDX_W + 1)'(NUM_FIELDS);

    record_assembler_state_e state_q, state_d;

    logic [FIELD_W-1:0]    fields [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] fill_mask, mask_base, mask_nxt, wr_sel;
    logic [REC_W-1:0]      rec_data;
    logic                  wr_acc, idx_ok, commit;
    logic                  fifo_full, fifo_empty;

    assign o_wr_ready  = !fifo_full;
    assign o_rec_valid = !fifo_empty;
    assign o_fill_mask = fill_mask;

    always_comb begin
        wr_acc    = i_wr_valid && !fifo_full;
        idx_ok    = ({1'b0, i_wr_field} < NF);
        mask_base = (state_q == IDLE) ? '0 : fill_mask;
        wr_sel    = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            wr_sel[i] = wr_acc && idx_ok && (i_wr_field == IDX_W'(i));
        end
        mask_nxt = mask_base | wr_sel;
        commit   = wr_acc && (i_wr_last || (idx_ok && (&mask_nxt)));
        // Field 0 lands in the record MSBs; unwritten fields take the fill value.
        rec_data = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            rec_data[(NUM_FIELDS-1-i)*FIELD_W +: FIELD_W] =
                !mask_nxt[i] ? DEFAULT_VAL : (wr_sel[i] ? i_wr_data : fields[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_acc && !commit && (|wr_sel)) state_d = FILL;
            FILL:    if (commit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            fill_mask <= '0;
            o_idx_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_mask <= commit ? '0 : mask_nxt;
            o_idx_err <= wr_acc && !idx_ok;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (commit) begin
                fields[i] <= '0;
            end else if (wr_sel[i]) begin
                fields[i] <= i_wr_data;
            end
        end
    end

`ifdef RECORD_ASSEMBLER_DUP_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_dup_err <= 1'b0;
        end else if (|(wr_sel & mask_base)) begin
            o_dup_err <= 1'b1;
        end
    end
`endif

    record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .push      (commit),
        .push_data (rec_data),
        .pop       (i_rec_ready),
        .head_data (o_rec_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_record_assembler.sv
// Scoreboard bench for record_assembler: two configurations (2x10 default-0, 3x10 default-5).
module tb_record_assembler;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        a_valid, a_field, a_last, a_wr_ready, a_rec_valid, a_rec_ready, a_idx_err;
    logic [9:0]  a_data;
    logic [19:0] a_rec_data;
    logic [1:0]  a_mask;

    logic        b_valid, b_last, b_wr_ready, b_rec_valid, b_rec_ready, b_idx_err;
    logic [1:0]  b_field;
    logic [9:0]  b_data;
    logic [29:0] b_rec_data;
    logic [2:0]  b_mask;

`ifdef RECORD_ASSEMBLER_DUP_CHECK_EN
    logic        a_dup, b_dup;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] q_a [$];
    logic [29:0] q_b [$];

    record_assembler u_a (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(a_valid), .i_wr_field(a_field),
        .i_wr_data(a_data), .i_wr_last(a_last), .o_wr_ready(a_wr_ready),
        .o_rec_valid(a_rec_valid), .o_rec_data(a_rec_data), .i_rec_ready(a_rec_ready),
        .o_fill_mask(a_mask), .o_idx_err(a_idx_err)
`ifdef RECORD_ASSEMBLER_DUP_CHECK_EN
        , .o_dup_err(a_dup)
`endif
    );

    record_assembler #(.FIELD_W(10), .NUM_FIELDS(3), .DEFAULT_VAL(10'd5), .DEPTH(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(b_valid), .i_wr_field(b_field),
        .i_wr_data(b_data), .i_wr_last(b_last), .o_wr_ready(b_wr_ready),
        .o_rec_valid(b_rec_valid), .o_rec_data(b_rec_data), .i_rec_ready(b_rec_ready),
        .o_fill_mask(b_mask), .o_idx_err(b_idx_err)
`ifdef RECORD_ASSEMBLER_DUP_CHECK_EN
        , .o_dup_err(b_dup)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed handshake is matched against the scoreboard head.
    always @(negedge clk) begin
        if (a_rec_valid && a_rec_ready) begin
            if (q_a.size() == 0) check("rec_a_unexpected", {12'd0, a_rec_data}, 32'hFFFFFFFF);
            else check("rec_a", {12'd0, a_rec_data}, {12'd0, q_a.pop_front()});
        end
        if (b_rec_valid && b_rec_ready) begin
            if (q_b.size() == 0) check("rec_b_unexpected", {2'd0, b_rec_data}, 32'hFFFFFFFF);
            else check("rec_b", {2'd0, b_rec_data}, {2'd0, q_b.pop_front()});
        end
    end

    task automatic wr(input bit on_b, input int f, input logic [9:0] d, input bit last);
        bit acc = 1'b0;
        if (on_b) begin
            b_valid = 1'b1; b_field = 2'(f); b_data = d; b_last = last;
        end else begin
            a_valid = 1'b1; a_field = 1'(f); a_data = d; a_last = last;
        end
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = on_b ? b_wr_ready : a_wr_ready;
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        if (!acc) check("wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        a_valid = 0; a_field = 0; a_data = 0; a_last = 0; a_rec_ready = 1;
        b_valid = 0; b_field = 0; b_data = 0; b_last = 0; b_rec_ready = 1;
        idle(3);
        check("rst_rec_valid", {31'd0, a_rec_valid}, 32'd0);
        check("rst_rec_data",  {12'd0, a_rec_data}, 32'd0);
        check("rst_mask",      {30'd0, a_mask}, 32'd0);
        check("rst_idx_err",   {31'd0, a_idx_err}, 32'd0);
        check("rst_wr_ready",  {31'd0, a_wr_ready}, 32'd1);
        rst = 1'b1;
        idle(1);

        // Two-field fill
        q_a.push_back(20'h0280A);
        wr(0, 0, 10'd10, 0);
        check("mask_after_f0", {30'd0, a_mask}, 32'd1);
        wr(0, 1, 10'd10, 0);
        check("commit_latency", {31'd0, a_rec_valid}, 32'd1);
        check("mask_after_commit", {30'd0, a_mask}, 32'd0);
        idle(2);

        // Early commit with default fill
        q_a.push_back(20'h02800);
        wr(0, 0, 10'd10, 1);
        q_b.push_back(30'h00A01405);
        wr(1, 0, 10'd10, 1);
        idle(2);

        // Backpressure: FIFO fills, third write stalls
        a_rec_ready = 1'b0;
        q_a.push_back(20'h00400);
        q_a.push_back(20'h00800);
        q_a.push_back(20'h00C00);
        wr(0, 0, 10'd1, 1);
        check("ready_one_entry", {31'd0, a_wr_ready}, 32'd1);
        wr(0, 0, 10'd2, 1);
        check("ready_drop_full", {31'd0, a_wr_ready}, 32'd0);
        a_valid = 1'b1; a_field = 1'b0; a_data = 10'd3; a_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_ready", {31'd0, a_wr_ready}, 32'd0);
            check("stall_mask", {30'd0, a_mask}, 32'd0);
            check("stall_head_stable", {12'd0, a_rec_data}, 32'h00400);
            @(posedge clk); #1;
        end
        a_rec_ready = 1'b1;
        @(posedge clk); #1;
        a_rec_ready = 1'b0;
        check("ready_after_pop", {31'd0, a_wr_ready}, 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("ready_full_again", {31'd0, a_wr_ready}, 32'd0);
        a_rec_ready = 1'b1;
        idle(4);

        // Reset with a full FIFO drops everything
        a_rec_ready = 1'b0;
        wr(0, 0, 10'd7, 1);
        wr(0, 0, 10'd8, 1);
        check("full_before_rst", {31'd0, a_wr_ready}, 32'd0);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        check("rst_full_valid", {31'd0, a_rec_valid}, 32'd0);
        check("rst_full_ready", {31'd0, a_wr_ready}, 32'd1);
        check("rst_full_data",  {12'd0, a_rec_data}, 32'd0);
        a_rec_ready = 1'b1;
        idle(1);

        // Out-of-range index on the three-field instance
        wr(1, 3, 10'd7, 0);
        check("idx_err_pulse", {31'd0, b_idx_err}, 32'd1);
        check("idx_err_mask", {29'd0, b_mask}, 32'd0);
        idle(1);
        check("idx_err_clear", {31'd0, b_idx_err}, 32'd0);
        check("idx_err_no_rec", {31'd0, b_rec_valid}, 32'd0);
        q_b.push_back(30'h00501405);
        wr(1, 3, 10'd9, 1);
        idle(2);
        q_b.push_back(30'h00200C01);
        wr(1, 2, 10'd1, 0);
        check("b_mask_f2", {29'd0, b_mask}, 32'd4);
        wr(1, 0, 10'd2, 0);
        check("b_mask_f2f0", {29'd0, b_mask}, 32'd5);
        wr(1, 1, 10'd3, 0);
        check("b_mask_commit", {29'd0, b_mask}, 32'd0);
        idle(2);

        // Reset mid-fill discards the partial record
        wr(0, 0, 10'd1, 0);
        check("partial_mask", {30'd0, a_mask}, 32'd1);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        check("mask_after_rst", {30'd0, a_mask}, 32'd0);
        q_a.push_back(20'h00C02);
        wr(0, 1, 10'd2, 0);
        check("mask_f1_only", {30'd0, a_mask}, 32'd2);
        wr(0, 0, 10'd3, 0);
        idle(2);

`ifdef RECORD_ASSEMBLER_DUP_CHECK_EN
        wr(0, 0, 10'd1, 0);
        check("dup_low", {31'd0, a_dup}, 32'd0);
        q_a.push_back(20'h01000);
        wr(0, 0, 10'd4, 0);
        check("dup_set", {31'd0, a_dup}, 32'd1);
        wr(0, 1, 10'd0, 0);
        idle(2);
        check("dup_sticky", {31'd0, a_dup}, 32'd1);
`endif

        idle(2);
        check("q_a_drained", q_a.size(), 32'd0);
        check("q_b_drained", q_b.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
